// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline has priority, the multicycle unit is forced after STARVE_MAX losses.
// Define WB_SCOREBOARD_EN to track outstanding multicycle destinations in pend_mask.
module wb_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_valid,
   input  logic [4:0]  p_wa,
   input  logic [31:0] p_wd,
   output logic        p_ready,
   input  logic        m_valid,
   input  logic [4:0]  m_wa,
   input  logic [31:0] m_wd,
   output logic        m_ready,
   input  logic        iss_en,
   input  logic [4:0]  iss_wa,
   output logic        we3,
   output logic [4:0]  wa3,
   output logic [31:0] wd3,
   output logic [31:0] pend_mask
);

   typedef enum logic {PRIO_P, FORCE_M} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;

   assign cnt_inc = cnt + 4'd1;

   // Grants are gated by reset so nothing is accepted while rst is low.
   always_comb begin
      p_ready = 1'b0;
      m_ready = 1'b0;
      if (rst) begin
         if (state == FORCE_M) begin
            m_ready = m_valid;
            p_ready = p_valid && !m_valid;
         end else begin
            p_ready = p_valid;
            m_ready = m_valid && !p_valid;
         end
      end
   end

   always_comb begin
      we3 = 1'b0;
      wa3 = 5'd0;
      wd3 = 32'd0;
      if (p_ready) begin
         wa3 = p_wa;
         wd3 = p_wd;
         we3 = (p_wa != 5'd0);
      end else if (m_ready) begin
         wa3 = m_wa;
         wd3 = m_wd;
         we3 = (m_wa != 5'd0);
      end
   end

   // FORCE_M lasts exactly one cycle whether or not the multicycle unit shows up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= PRIO_P;
         cnt   <= 4'd0;
      end else begin
         case (state)
            PRIO_P: begin
               if (p_valid && m_valid) begin
                  if (cnt_inc == 4'(STARVE_MAX)) begin
                     state <= FORCE_M;
                     cnt   <= 4'd0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end else if (m_valid) begin
                  cnt <= 4'd0;
               end
            end
            default: begin
               state <= PRIO_P;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [31:0] pend_q;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;

   always_comb begin
      set_vec = 32'd0;
      clr_vec = 32'd0;
      if (iss_en && iss_wa != 5'd0) set_vec[iss_wa] = 1'b1;
      if (m_ready) clr_vec[m_wa] = 1'b1;
   end

   // Set is OR-ed after the clear so a same-cycle re-issue keeps the bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend_q <= 32'd0;
      else      pend_q <= ((pend_q & ~clr_vec) | set_vec) & ~32'd1;
   end

   assign pend_mask = pend_q;
`else
   logic unused_iss;
   assign unused_iss = iss_en ^ (^iss_wa);
   assign pend_mask  = 32'd0;
`endif

endmodule
